// File: rtl/mem_wb_stage.sv
// mem_wb_stage: retires instructions from the EX-stage pipeline register.
// A retirement is either a single-cycle register-file write or a req/ack store to
// data memory. The stage freezes upstream logic while a store is outstanding or the
// core has halted.
// Optional feature: define MEM_TIMEOUT_EN to abort stores that wait longer than
// TIMEOUT_CYC cycles for an ack (flags mem_err and halts the core).
module mem_wb_stage #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              halted,
  input  logic              data_rw,
  input  logic [DATA_W-1:0] alu_output,
  input  logic [ADDR_W-1:0] write_addr,
  output logic              freeze,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              dm_req,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  output logic              core_halted,
  output logic              mem_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              dm_req_q, dm_req_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              core_halted_q, core_halted_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
`endif

  // Next-state and registered-output logic for the retire FSM.
  always_comb begin
    state_d       = state_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    dm_req_d      = dm_req_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    core_halted_d = core_halted_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // HALT outranks any retirement carried by the same instruction.
          if (halted) begin
            state_d       = StHalt;
            core_halted_d = 1'b1;
          end else if (!data_rw) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = write_addr;
            rf_wdata_d = alu_output;
          end else begin
            dm_req_d   = 1'b1;
            dm_addr_d  = write_addr;
            dm_wdata_d = alu_output;
            state_d    = StWait;
`ifdef MEM_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end
        end
      end

      StWait: begin
        // An ack on the expiry edge still completes the store normally.
        if (dm_ack) begin
          dm_req_d = 1'b0;
          state_d  = StIdle;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            dm_req_d      = 1'b0;
            mem_err_d     = 1'b1;
            core_halted_d = 1'b1;
            state_d       = StHalt;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
      end

      StHalt: begin
        dm_req_d      = 1'b0;
        core_halted_d = 1'b1;
      end

      default: begin
        state_d  = StIdle;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      dm_req_q      <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      core_halted_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      dm_req_q      <= dm_req_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      core_halted_q <= core_halted_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Store-timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign freeze      = (state_q != StIdle);
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign dm_req      = dm_req_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign core_halted = core_halted_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model of the retire stage.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned TIMEOUT_CYC = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              halted = 1'b0;
  logic              data_rw = 1'b0;
  logic [DATA_W-1:0] alu_output = '0;
  logic [ADDR_W-1:0] write_addr = '0;
  logic              dm_ack = 1'b0;
  logic              freeze, rf_we, dm_req, core_halted, mem_err;
  logic [ADDR_W-1:0] rf_waddr, dm_addr;
  logic [DATA_W-1:0] rf_wdata, dm_wdata;

  mem_wb_stage #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .halted     (halted),
    .data_rw    (data_rw),
    .alu_output (alu_output),
    .write_addr (write_addr),
    .freeze     (freeze),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .dm_req     (dm_req),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .core_halted(core_halted),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Transaction-level reference: a store in flight, a stopped core, and the last retirement.
  bit              m_store_busy, m_stopped, m_err;
  bit              m_rf_we;
  logic [ADDR_W-1:0] m_rf_addr, m_st_addr;
  logic [DATA_W-1:0] m_rf_data, m_st_data;
  int              m_wait_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_store_busy  = 0;
    m_stopped     = 0;
    m_err         = 0;
    m_rf_we       = 0;
    m_wait_cycles = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    m_rf_we = 0;
    if (m_stopped) begin
      // terminal
    end else if (m_store_busy) begin
      if (dm_ack) begin
        m_store_busy = 0;
      end else begin
        m_wait_cycles++;
`ifdef MEM_TIMEOUT_EN
        if (m_wait_cycles == TIMEOUT_CYC) begin
          m_store_busy = 0;
          m_err        = 1;
          m_stopped    = 1;
        end
`endif
      end
    end else if (in_valid) begin
      if (halted) begin
        m_stopped = 1;
      end else if (!data_rw) begin
        m_rf_we   = 1;
        m_rf_addr = write_addr;
        m_rf_data = alu_output;
      end else begin
        m_store_busy  = 1;
        m_st_addr     = write_addr;
        m_st_data     = alu_output;
        m_wait_cycles = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_rf_we));
    chk({tag, ".dm_req"}, 32'(dm_req), 32'(m_store_busy));
    chk({tag, ".freeze"}, 32'(freeze), 32'(m_store_busy | m_stopped));
    chk({tag, ".core_halted"}, 32'(core_halted), 32'(m_stopped));
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(m_err));
    if (m_rf_we) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_rf_addr));
      chk({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(m_rf_data));
    end
    if (m_store_busy) begin
      chk({tag, ".dm_addr"}, 32'(dm_addr), 32'(m_st_addr));
      chk({tag, ".dm_wdata"}, 32'(dm_wdata), 32'(m_st_data));
    end
  endtask

  // One clock: model steps, DUT clocks, outputs sampled 1ns after the edge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit v, input bit h, input bit rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit ack);
    in_valid   = v;
    halted     = h;
    data_rw    = rw;
    write_addr = a;
    alu_output = d;
    dm_ack     = ack;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst.freeze"}, 32'(freeze), 32'd0);
    chk({tag, ".rst.dm_req"}, 32'(dm_req), 32'd0);
    chk({tag, ".rst.rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, ".rst.core_halted"}, 32'(core_halted), 32'd0);
    chk({tag, ".rst.mem_err"}, 32'(mem_err), 32'd0);
    chk({tag, ".rst.dm_addr"}, 32'(dm_addr), 32'd0);
    chk({tag, ".rst.rf_wdata"}, 32'(rf_wdata), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit                v, rw, ack;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                e_we, e_req, e_frz;
    logic [ADDR_W-1:0] e_a;
    logic [DATA_W-1:0] e_d;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // v rw ack addr data | we req frz exp_addr exp_data
    vecs[0]  = '{1, 0, 0, 6'h05, 8'hA5, 1, 0, 0, 6'h05, 8'hA5};
    vecs[1]  = '{0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00};
    vecs[2]  = '{1, 0, 0, 6'h01, 8'h11, 1, 0, 0, 6'h01, 8'h11};
    vecs[3]  = '{1, 0, 0, 6'h02, 8'h22, 1, 0, 0, 6'h02, 8'h22};
    vecs[4]  = '{1, 0, 0, 6'h03, 8'h33, 1, 0, 0, 6'h03, 8'h33};
    vecs[5]  = '{0, 0, 1, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00};
    vecs[6]  = '{1, 1, 0, 6'h3F, 8'h3C, 0, 1, 1, 6'h3F, 8'h3C};
    vecs[7]  = '{1, 0, 0, 6'h07, 8'h77, 0, 1, 1, 6'h3F, 8'h3C};
    vecs[8]  = '{1, 1, 0, 6'h09, 8'h99, 0, 1, 1, 6'h3F, 8'h3C};
    vecs[9]  = '{0, 0, 1, 6'h00, 8'h00, 0, 0, 0, 6'h00, 8'h00};
    vecs[10] = '{1, 0, 0, 6'h08, 8'h88, 1, 0, 0, 6'h08, 8'h88};

    model_reset();
    #3;
    chk("reset.freeze", 32'(freeze), 32'd0);
    chk("reset.dm_req", 32'(dm_req), 32'd0);
    chk("reset.rf_we", 32'(rf_we), 32'd0);
    chk("reset.core_halted", 32'(core_halted), 32'd0);
    chk("reset.mem_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vector table: reg writes, back-to-back writes, store with ack after 3 cycles.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, 1'b0, vecs[i].rw, vecs[i].a, vecs[i].d, vecs[i].ack);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d.req", i), 32'(dm_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d.freeze", i), 32'(freeze), 32'(vecs[i].e_frz));
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d.rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_a));
        chk($sformatf("vec%0d.rf_wdata", i), 32'(rf_wdata), 32'(vecs[i].e_d));
      end
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d.dm_addr", i), 32'(dm_addr), 32'(vecs[i].e_a));
        chk($sformatf("vec%0d.dm_wdata", i), 32'(dm_wdata), 32'(vecs[i].e_d));
      end
    end
    drive(0, 0, 0, '0, '0, 0);
    cycle("vec_tail");
    chk("vec_tail.we", 32'(rf_we), 32'd0);

    // Halt outranks store; then nothing changes for 10 cycles of noisy inputs.
    drive(1, 1, 1, 6'h2A, 8'h5A, 0);
    cycle("halt");
    chk("halt.core_halted", 32'(core_halted), 32'd1);
    chk("halt.freeze", 32'(freeze), 32'd1);
    chk("halt.dm_req", 32'(dm_req), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1, i[0], ~i[0], 6'(i), 8'(i * 7), i[1]);
      cycle($sformatf("halt_hold%0d", i));
      chk($sformatf("halt_hold%0d.dm_req", i), 32'(dm_req), 32'd0);
      chk($sformatf("halt_hold%0d.rf_we", i), 32'(rf_we), 32'd0);
    end
    do_reset("halt");

    // Reset while a store is waiting, then a reg write retires normally.
    drive(1, 0, 1, 6'h12, 8'hC3, 0);
    cycle("midstore");
    chk("midstore.dm_req", 32'(dm_req), 32'd1);
    drive(0, 0, 0, '0, '0, 0);
    cycle("midstore_wait");
    do_reset("midstore");
    drive(1, 0, 0, 6'h21, 8'h4E, 0);
    cycle("after_rst");
    chk("after_rst.rf_we", 32'(rf_we), 32'd1);
    chk("after_rst.rf_wdata", 32'(rf_wdata), 32'h4E);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort exactly on the 15th wait edge.
    drive(1, 0, 1, 6'h30, 8'hE1, 0);
    cycle("to_store");
    drive(0, 0, 0, '0, '0, 0);
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      cycle($sformatf("to_wait%0d", i));
      chk($sformatf("to_wait%0d.dm_req", i), 32'(dm_req), 32'd1);
    end
    cycle("to_expire");
    chk("to_expire.dm_req", 32'(dm_req), 32'd0);
    chk("to_expire.mem_err", 32'(mem_err), 32'd1);
    chk("to_expire.core_halted", 32'(core_halted), 32'd1);
    do_reset("to");
    // Ack arriving on the expiry edge completes normally.
    drive(1, 0, 1, 6'h31, 8'hE2, 0);
    cycle("tok_store");
    drive(0, 0, 0, '0, '0, 0);
    for (int i = 1; i < TIMEOUT_CYC; i++) cycle($sformatf("tok_wait%0d", i));
    dm_ack = 1'b1;
    cycle("tok_ack");
    chk("tok_ack.dm_req", 32'(dm_req), 32'd0);
    chk("tok_ack.mem_err", 32'(mem_err), 32'd0);
    chk("tok_ack.freeze", 32'(freeze), 32'd0);
`else
    // Without the timeout a store waits indefinitely for its ack.
    drive(1, 0, 1, 6'h30, 8'hE1, 0);
    cycle("long_store");
    drive(0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) cycle($sformatf("long_wait%0d", i));
    chk("long_wait.dm_req", 32'(dm_req), 32'd1);
    chk("long_wait.mem_err", 32'(mem_err), 32'd0);
    dm_ack = 1'b1;
    cycle("long_ack");
    chk("long_ack.freeze", 32'(freeze), 32'd0);
`endif
    drive(0, 0, 0, '0, '0, 0);
    cycle("settle");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ((m_stopped && $urandom_range(0, 7) == 0) || $urandom_range(0, 79) == 0) begin
        do_reset($sformatf("rnd%0d", i));
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'($urandom),
            ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 2) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
